// File: rtl/vx_alu_req_queue.sv
`default_nettype none
// ============================================================================
// Module   : vx_alu_req_queue
// Brief    : Elastic, fully registered request queue from dispatch to the ALU.
//            Zero-thread-mask requests are consumed and dropped on entry.
// Revision : 1.0 - initial release
// ============================================================================
module vx_alu_req_queue #(
    parameter int DEPTH         = 4,
    parameter int UUID_BITS     = 44,
    parameter int NW_BITS       = 2,
    parameter int NUM_THREADS   = 4,
    parameter int INST_ALU_BITS = 4,
    parameter int INST_MOD_BITS = 3,
    parameter int NT_BITS       = 2,
    parameter int NR_BITS       = 5,
    parameter int DATAW         = UUID_BITS + NW_BITS + NUM_THREADS + 32 + 32
                                + INST_ALU_BITS + INST_MOD_BITS + 1 + 1 + 32
                                + NT_BITS + 2 * NUM_THREADS * 32 + NR_BITS + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [DATAW-1:0]         in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [DATAW-1:0]         out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_ptr_w    = $clog2(DEPTH);
    localparam int c_cnt_w    = c_ptr_w + 1;
    localparam int c_buf_d    = DEPTH - 1;
    localparam int c_tmask_hi = DATAW - UUID_BITS - NW_BITS - 1;

    logic [DATAW-1:0]   r_mem [c_buf_d];
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_rptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_out_valid;
    logic [DATAW-1:0]   r_out_data;

    logic               w_in_ready;
    logic               w_push;
    logic               w_push_stored;
    logic               w_pop;
    logic               w_head_load;
    logic               w_buf_empty;
    logic               w_buf_wr;
    logic               w_buf_rd;
    logic [c_ptr_w-1:0] w_wptr_nxt;
    logic [c_ptr_w-1:0] w_rptr_nxt;

    assign w_in_ready    = !reset && (r_count < c_cnt_w'(DEPTH));
    assign w_push        = in_valid && w_in_ready;
    assign w_push_stored = w_push && (in_data[c_tmask_hi -: NUM_THREADS] != '0);
    assign w_pop         = r_out_valid && out_ready;
    assign w_head_load   = !r_out_valid || w_pop;
    // The head is always refilled when free, so buffered = count - head occupancy.
    assign w_buf_empty   = (r_count == c_cnt_w'(r_out_valid));
    assign w_buf_wr      = w_push_stored && !(w_head_load && w_buf_empty);
    assign w_buf_rd      = w_head_load && !w_buf_empty;

    // Buffer holds DEPTH-1 entries, so pointers wrap explicitly rather than by rollover.
    assign w_wptr_nxt = (r_wptr == c_ptr_w'(c_buf_d - 1)) ? '0 : r_wptr + 1'b1;
    assign w_rptr_nxt = (r_rptr == c_ptr_w'(c_buf_d - 1)) ? '0 : r_rptr + 1'b1;

    always_ff @(posedge clk) begin
        if (w_buf_wr) begin
            r_mem[r_wptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_buf_wr) begin
                r_wptr <= w_wptr_nxt;
            end
            if (w_buf_rd) begin
                r_rptr <= w_rptr_nxt;
            end
            if (w_head_load) begin
                if (!w_buf_empty) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= r_mem[r_rptr];
                end else if (w_push_stored) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= in_data;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end
            r_count <= r_count + c_cnt_w'(w_push_stored) - c_cnt_w'(w_pop);
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign count     = r_count;

`ifndef SYNTHESIS
    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        r_count <= c_cnt_w'(DEPTH));
    a_no_push_full: assert property (@(posedge clk) disable iff (reset)
        w_push_stored |-> (r_count < c_cnt_w'(DEPTH)));
    a_out_stable: assert property (@(posedge clk) disable iff (reset)
        (r_out_valid && !out_ready) |=> (r_out_valid && $stable(r_out_data)));
`endif

endmodule
`default_nettype wire

// File: doc/vx_alu_req_queue.md
Name: vx_alu_req_queue

Overview:
- Elastic request queue between the dispatch stage (producer of ALU requests) and the ALU unit (consumer).
- Decouples dispatch from ALU backpressure. Holds up to DEPTH complete ALU requests in issue order.
- Presents a fully registered valid/ready interface on both sides, so there is no combinational path from input to output or from out_ready to in_ready.
- Requests with an all-zero thread mask are dropped at entry.

Parameters:
- DEPTH, 4, queue capacity in requests; power of two, minimum 2.
- DATAW, UUID_BITS+NW_BITS+NUM_THREADS+32+32+INST_ALU_BITS+INST_MOD_BITS+1+1+32+NT_BITS+2*NUM_THREADS*32+NR_BITS+1, packed request width; never overridden.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  dispatch request valid
- in_data  input  DATAW  packed request, field order MSB→LSB: uuid, wid, tmask, PC, next_PC, op_type, op_mod, use_PC, use_imm, imm, tid, rs1_data, rs2_data, rd, wb
- in_ready  output  1  queue can accept a request
- out_valid  output  1  head request valid to ALU
- out_data  output  DATAW  head request, same packing
- out_ready  input  1  ALU accepts head
- count  output  $clog2(DEPTH)+1  stored requests, including the head register

Behaviour:
- Handshake
  - Transfer occurs on a rising clk edge where valid&&ready.
  - A producer holding valid must keep data stable until ready.
  - The queue holds out_valid/out_data stable until out_ready.
- Entry filter
  - tmask field is in_data[DATAW-UUID_BITS-NW_BITS-1 -: NUM_THREADS].
  - A handshaken request with tmask==0 is consumed: in_ready is honoured, but nothing is stored and count is unchanged.
- Storage
  - Circular buffer of DEPTH-1 entries plus one output register (head). Total capacity is DEPTH.
  - Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH-1 entries; use an explicit wrap compare, not a power-of-two rollover.
- in_ready = !reset && (count < DEPTH). It depends only on registered count, not on out_ready.
  - When full, a simultaneous pop does not allow a same-cycle push.
- Latency
  - A request pushed into an empty queue appears on out_valid the next cycle (1-cycle minimum).
  - Sustained throughput is one request per cycle when the consumer is always ready.
- Head refill
  - On pop, or when the head is empty, the head loads the oldest buffered entry.
  - If the buffer is empty and a push is occurring, the incoming request loads the head directly (bypass into the register, still registered).
- Count update: count_next = count + push_stored − pop. Simultaneous push and pop at 0<count<DEPTH leaves count unchanged.
- Order is strict FIFO; no reordering across warps.
- Reset (synchronous)
  - out_valid=0, out_data=0, count=0, pointers=0, in_ready=0 during reset.
  - in_ready=1 on the first cycle after reset deasserts.
  - Reset mid-operation discards all stored requests; nothing is emitted afterward.
- Assertions (sim only): count never exceeds DEPTH; no push when !in_ready; out_data stable while out_valid&&!out_ready.

Test Plan:
- Single pass: DEPTH=4, out_ready=1, one request with uuid=5, tmask=4'b0011 → out_valid high exactly 1 cycle after the handshake, out_data bit-identical, count 1 then 0.
- Fill/backpressure: out_ready=0, push 6 back-to-back requests (uuid 1..6) → 4 accepted, in_ready=0 from cycle 4 onward, count=4. Release out_ready → uuid 1,2,3,4 emitted in order on consecutive cycles.
- Streaming: out_ready=1, 100 consecutive requests → 100 outputs in order, one per cycle, count≤1 throughout.
- Full plus simultaneous pop: count=4, in_valid=1, out_ready=1 → pop occurs, push rejected, count=3. Next cycle push accepted and count stays 3.
- Zero-mask drop: push uuid=7 with tmask=0, then uuid=8 with tmask=4'b1000 → only uuid=8 emitted, count peaks at 1.
- Reset mid-operation: count=3, assert reset 1 cycle → out_valid=0, count=0, in_ready=0 during reset, 1 after. None of the 3 old requests ever appear.
